// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex sample type and a ceil-log2 helper for the FFT datapath.
package fft_pkg;

    localparam int unsigned DW = 16;

    // Largest positive Q1.15 value; unity twiddle uses this so -1.0 never appears.
    localparam logic [DW-1:0] Q15_ONE = 16'h7FFF;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // Ceil-log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/r2mdc_twiddle_rom.sv
// r2mdc_twiddle_rom: synchronous twiddle ROM, W(m) = cos(2*pi*m/N) - j*sin(2*pi*m/N) in Q1.15.
// Built from a 17-entry quarter-wave sine table (64-point grid), so N = 2*NUM_INPUTS_PER_PATH
// may be any power of two from 4 to 64. Values are round(32767 * sin), DW >= 16 assumed.
module r2mdc_twiddle_rom #(
    parameter int unsigned NUM_INPUTS_PER_PATH = 32,
    parameter int unsigned DW                  = 16,
    parameter int unsigned AW                  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en_i,
    input  logic [AW-1:0]        addr_i,
    output logic signed [DW-1:0] w_re_o,
    output logic signed [DW-1:0] w_im_o
);
    import fft_pkg::*;

    // Stride into the 64-point grid for smaller transforms.
    localparam int unsigned Step  = clog2(32 / NUM_INPUTS_PER_PATH);
    localparam int unsigned Shift = DW - 16;

    logic signed [DW-1:0] w_re_q, w_im_q;
    int                   grid_idx;
    int                   cos_v;
    int                   sin_v;

    function automatic int sin_q(input int idx);
        int r;
        case (idx)
            0:       r = 0;
            1:       r = 3212;
            2:       r = 6393;
            3:       r = 9512;
            4:       r = 12539;
            5:       r = 15446;
            6:       r = 18204;
            7:       r = 20787;
            8:       r = 23170;
            9:       r = 25329;
            10:      r = 27245;
            11:      r = 28898;
            12:      r = 30273;
            13:      r = 31356;
            14:      r = 32137;
            15:      r = 32609;
            16:      r = int'(Q15_ONE);
            default: r = 0;
        endcase
        return r;
    endfunction

    // Fold the half-circle index onto the quarter-wave table.
    always_comb begin
        grid_idx = int'(addr_i) << Step;
        if (grid_idx <= 16) begin
            cos_v = sin_q(16 - grid_idx);
            sin_v = sin_q(grid_idx);
        end else begin
            cos_v = -sin_q(grid_idx - 16);
            sin_v = sin_q(32 - grid_idx);
        end
    end

    // Registered read; holds on cycles without a valid address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_re_q <= '0;
            w_im_q <= '0;
        end else if (en_i) begin
            w_re_q <= DW'(cos_v <<< Shift);
            w_im_q <= DW'(-sin_v <<< Shift);
        end
    end

    assign w_re_o = w_re_q;
    assign w_im_o = w_im_q;

endmodule

// File: rtl/r2mdc_butterfly_stage.sv
// r2mdc_butterfly_stage: radix-2 DIF butterfly and twiddle multiply for one R2MDC stage.
// Register ranks: P1 add/sub (twiddle ROM read in parallel), P2 products, P3 combine/output.
// Option macro BF_ROUND_EN: round half up on the twiddled path; default is truncation.
module r2mdc_butterfly_stage #(
    parameter int unsigned NUM_INPUTS_PER_PATH = 32,
    parameter int unsigned STAGE               = 0,
    parameter int unsigned DW                  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] bf_in0_re,
    input  logic signed [DW-1:0] bf_in0_im,
    input  logic signed [DW-1:0] bf_in1_re,
    input  logic signed [DW-1:0] bf_in1_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] bf_out0_re,
    output logic signed [DW-1:0] bf_out0_im,
    output logic signed [DW-1:0] bf_out1_re,
    output logic signed [DW-1:0] bf_out1_im,
    output logic                 out_frame_start
);
    import fft_pkg::*;

    localparam int unsigned           Kw       = clog2(NUM_INPUTS_PER_PATH);
    localparam int unsigned           Span     = NUM_INPUTS_PER_PATH >> STAGE;
    localparam logic [Kw-1:0]         SpanMask = Kw'(Span - 1);
`ifdef BF_ROUND_EN
    localparam logic signed [2*DW:0]  RoundBias = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};
`else
    localparam logic signed [2*DW:0]  RoundBias = '0;
`endif

    // Pair counter and twiddle index
    logic [Kw-1:0] k_q, k_d;
    logic [Kw-1:0] m_d;

    // P1
    logic                 v1_q, f1_q;
    logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
    logic signed [DW-1:0] s1_re_q, s1_im_q, d1_re_q, d1_im_q;
    logic signed [DW-1:0] w_re, w_im;

    // P2
    logic                   v2_q, f2_q;
    logic signed [DW-1:0]   s2_re_q, s2_im_q;
    logic signed [2*DW-1:0] pr_q, pi_q, qr_q, qi_q;

    // P3
    logic signed [2*DW:0] re_full, im_full;
    logic                 v3_q, fs3_q;
    logic signed [DW-1:0] o0_re_q, o0_im_q, o1_re_q, o1_im_q;
    logic                 unused_bits;

    // Counter advances once per accepted pair and wraps at the frame length.
    always_comb begin
        k_d = in_valid ? k_q + 1'b1 : k_q;
        m_d = (k_q & SpanMask) << STAGE;
    end

    // Pair counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Sign-extended add/sub; the halving shift keeps the result in DW bits.
    always_comb begin
        sum_re = {bf_in0_re[DW-1], bf_in0_re} + {bf_in1_re[DW-1], bf_in1_re};
        sum_im = {bf_in0_im[DW-1], bf_in0_im} + {bf_in1_im[DW-1], bf_in1_im};
        dif_re = {bf_in0_re[DW-1], bf_in0_re} - {bf_in1_re[DW-1], bf_in1_re};
        dif_im = {bf_in0_im[DW-1], bf_in0_im} - {bf_in1_im[DW-1], bf_in1_im};
    end

    // The ROM's address register acts as the P1 copy of m: W arrives alongside d.
    r2mdc_twiddle_rom #(
        .NUM_INPUTS_PER_PATH (NUM_INPUTS_PER_PATH),
        .DW                  (DW),
        .AW                  (Kw)
    ) u_twiddle_rom (
        .CLK    (CLK),
        .RST    (RST),
        .en_i   (in_valid),
        .addr_i (m_d),
        .w_re_o (w_re),
        .w_im_o (w_im)
    );

    // P1 register: butterfly sum/difference and frame flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            s1_re_q <= '0;
            s1_im_q <= '0;
            d1_re_q <= '0;
            d1_im_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                f1_q    <= (k_q == '0);
                s1_re_q <= sum_re[DW:1];
                s1_im_q <= sum_im[DW:1];
                d1_re_q <= dif_re[DW:1];
                d1_im_q <= dif_im[DW:1];
            end
        end
    end

    // P2 register: four partial products, sum path delayed
    always_ff @(posedge CLK) begin
        if (RST) begin
            v2_q    <= 1'b0;
            f2_q    <= 1'b0;
            s2_re_q <= '0;
            s2_im_q <= '0;
            pr_q    <= '0;
            pi_q    <= '0;
            qr_q    <= '0;
            qi_q    <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                f2_q    <= f1_q;
                s2_re_q <= s1_re_q;
                s2_im_q <= s1_im_q;
                pr_q    <= (2*DW)'(d1_re_q) * (2*DW)'(w_re);
                pi_q    <= (2*DW)'(d1_im_q) * (2*DW)'(w_im);
                qr_q    <= (2*DW)'(d1_re_q) * (2*DW)'(w_im);
                qi_q    <= (2*DW)'(d1_im_q) * (2*DW)'(w_re);
            end
        end
    end

    // Complex combine; |d| <= 1 and |W| < 1 keep the Q2.30 result inside the slice.
    always_comb begin
        re_full = (2*DW+1)'(pr_q) - (2*DW+1)'(pi_q) + RoundBias;
        im_full = (2*DW+1)'(qr_q) + (2*DW+1)'(qi_q) + RoundBias;
    end

    // P3 register: outputs; data holds through bubbles
    always_ff @(posedge CLK) begin
        if (RST) begin
            v3_q    <= 1'b0;
            fs3_q   <= 1'b0;
            o0_re_q <= '0;
            o0_im_q <= '0;
            o1_re_q <= '0;
            o1_im_q <= '0;
        end else begin
            v3_q  <= v2_q;
            fs3_q <= v2_q & f2_q;
            if (v2_q) begin
                o0_re_q <= s2_re_q;
                o0_im_q <= s2_im_q;
                o1_re_q <= re_full[2*DW-2:DW-1];
                o1_im_q <= im_full[2*DW-2:DW-1];
            end
        end
    end

    assign out_valid       = v3_q;
    assign out_frame_start = fs3_q;
    assign bf_out0_re      = o0_re_q;
    assign bf_out0_im      = o0_im_q;
    assign bf_out1_re      = o1_re_q;
    assign bf_out1_im      = o1_im_q;

    // Discarded guard and fraction bits
    assign unused_bits = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0],
                           re_full[2*DW:2*DW-1], re_full[DW-2:0],
                           im_full[2*DW:2*DW-1], im_full[DW-2:0]};

endmodule

// File: tb/tb_r2mdc_butterfly_stage.sv
// tb_r2mdc_butterfly_stage: directed vectors with literal expectations plus an arithmetic
// reference model (real-valued twiddles, integer butterfly) checked on every output cycle.
module tb_r2mdc_butterfly_stage;

    localparam int unsigned Nipp  = 32;
    localparam int unsigned Stage = 0;
    localparam int unsigned Span  = Nipp >> Stage;
    localparam int unsigned NPts  = 2 * Nipp;
`ifdef BF_ROUND_EN
    localparam longint      Bias    = 64'sd16384;
    localparam logic [15:0] L1Test2 = 16'h1000;
`else
    localparam longint      Bias    = 64'sd0;
    localparam logic [15:0] L1Test2 = 16'h0FFF;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic        out_valid, out_frame_start;
    logic [15:0] o0_re, o0_im, o1_re, o1_im;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit              v;
        bit              fs;
        bit              tag5;
        logic [3:0][15:0] o;
        bit              lit;
        bit              lfs;
        logic [3:0][15:0] l;
    } exp_t;

    exp_t             pipe[3];
    int               mk;
    bit               chk_en = 1'b0;
    bit               tag5   = 1'b0;
    bit               lit_en = 1'b0;
    bit               lit_fs = 1'b0;
    logic [3:0][15:0] lit_val = '0;
    int               opair  = 0;

    always #5 CLK = ~CLK;

    r2mdc_butterfly_stage #(
        .NUM_INPUTS_PER_PATH (Nipp),
        .STAGE               (Stage),
        .DW                  (16)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .in_valid        (in_valid),
        .bf_in0_re       (a_re),
        .bf_in0_im       (a_im),
        .bf_in1_re       (b_re),
        .bf_in1_im       (b_im),
        .out_valid       (out_valid),
        .bf_out0_re      (o0_re),
        .bf_out0_im      (o0_im),
        .bf_out1_re      (o1_re),
        .bf_out1_im      (o1_im),
        .out_frame_start (out_frame_start)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Reference: (A+B)/2 and ((A-B)/2)*exp(-j*2*pi*m/N), floor scaling to Q1.15.
    function automatic logic [3:0][15:0] model(input logic [15:0] ar, ai, br, bi, input int k);
        int               xr, xi, yr, yi, sr, si, dr, di, m, wr, wi;
        real              ang;
        longint           re, im;
        logic [3:0][15:0] r;
        xr  = int'($signed(ar));
        xi  = int'($signed(ai));
        yr  = int'($signed(br));
        yi  = int'($signed(bi));
        sr  = (xr + yr) >>> 1;
        si  = (xi + yi) >>> 1;
        dr  = (xr - yr) >>> 1;
        di  = (xi - yi) >>> 1;
        m   = (k % int'(Span)) * (1 << Stage);
        ang = 2.0 * 3.14159265358979 * real'(m) / real'(NPts);
        wr  = rnd(32767.0 * $cos(ang));
        wi  = rnd(-32767.0 * $sin(ang));
        re  = longint'(dr) * longint'(wr) - longint'(di) * longint'(wi) + Bias;
        im  = longint'(dr) * longint'(wi) + longint'(di) * longint'(wr) + Bias;
        r[0] = 16'(sr);
        r[1] = 16'(si);
        r[2] = 16'(re >>> 15);
        r[3] = 16'(im >>> 15);
        return r;
    endfunction

    // Model: each accepted pair emerges three edges later; reset empties the pipe.
    always @(posedge CLK) begin
        exp_t e;
        e = '{v: 1'b0, fs: 1'b0, tag5: 1'b0, o: '0, lit: 1'b0, lfs: 1'b0, l: '0};
        if (RST) begin
            mk      <= 0;
            pipe[0] <= e;
            pipe[1] <= e;
            pipe[2] <= e;
        end else begin
            if (in_valid) begin
                e.v    = 1'b1;
                e.fs   = (mk == 0);
                e.tag5 = tag5;
                e.lit  = lit_en;
                e.lfs  = lit_fs;
                e.l    = lit_val;
                e.o    = model(a_re, a_im, b_re, b_im, mk);
                mk <= (mk + 1) % int'(Nipp);
            end
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= e;
        end
    end

    // Compare on the falling edge, away from DUT updates.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("out_valid", 16'(out_valid), 16'(pipe[2].v));
            chk("frame_start", 16'(out_frame_start), 16'(pipe[2].v && pipe[2].fs));
            if (pipe[2].v) begin
                chk("out0_re", o0_re, pipe[2].o[0]);
                chk("out0_im", o0_im, pipe[2].o[1]);
                chk("out1_re", o1_re, pipe[2].o[2]);
                chk("out1_im", o1_im, pipe[2].o[3]);
                if (pipe[2].lit) begin
                    chk("lit_out0_re", o0_re, pipe[2].l[0]);
                    chk("lit_out0_im", o0_im, pipe[2].l[1]);
                    chk("lit_out1_re", o1_re, pipe[2].l[2]);
                    chk("lit_out1_im", o1_im, pipe[2].l[3]);
                    chk("lit_frame_start", 16'(out_frame_start), 16'(pipe[2].lfs));
                end
                if (pipe[2].tag5) begin
                    chk("frame_pos", 16'(out_frame_start),
                        16'((opair + 1 == 1) || (opair + 1 == 33)));
                    opair <= opair + 1;
                end
            end
        end
    end

    task automatic set_lit(input logic [15:0] l0r, l0i, l1r, l1i, input bit fs);
        lit_en  = 1'b1;
        lit_fs  = fs;
        lit_val = {l1i, l1r, l0i, l0r};
    endtask

    task automatic send(input logic [15:0] ar, ai, br, bi);
        in_valid = 1'b1;
        a_re = ar;
        a_im = ai;
        b_re = br;
        b_im = bi;
        @(negedge CLK);
        lit_en = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a_re = 'x;
        a_im = 'x;
        b_re = 'x;
        b_im = 'x;
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b1;
        a_re = 16'h1234;
        a_im = 16'h5678;
        b_re = 16'h9ABC;
        b_im = 16'hDEF0;

        // Reset held two cycles with in_valid high: everything stays zero.
        repeat (2) begin
            @(negedge CLK);
            chk_en = 1'b1;
            chk("rst_valid", 16'(out_valid), 16'h0);
            chk("rst_fs", 16'(out_frame_start), 16'h0);
            chk("rst_out0_re", o0_re, 16'h0);
            chk("rst_out0_im", o0_im, 16'h0);
            chk("rst_out1_re", o1_re, 16'h0);
            chk("rst_out1_im", o1_im, 16'h0);
            a_re = 16'($urandom);
            b_re = 16'($urandom);
        end
        RST = 1'b0;

        // k=0, W=1: first pair after reset starts a frame.
        set_lit(16'h3000, 16'h0000, L1Test2, 16'h0000, 1'b1);
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000);
        idle(3);

        // k=16, W=-j.
        for (int i = 1; i < 16; i++) send_rand();
        set_lit(16'h2000, 16'h0000, 16'h0000, 16'hF000, 1'b0);
        send(16'h3000, 16'h0000, 16'h1000, 16'h0000);
        idle(4);

        // Extremes.
        pulse_reset();
        set_lit(16'hFFFF, 16'h0000, 16'h8001, 16'h0000, 1'b1);
        send(16'h8000, 16'h0000, 16'h7FFF, 16'h0000);
        set_lit(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        send(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
        idle(4);

        // Two frames with random bubbles.
        pulse_reset();
        for (int i = 0; i < 64; i++) begin
            idle(int'($urandom_range(0, 2)));
            tag5 = 1'b1;
            send_rand();
            tag5 = 1'b0;
        end
        idle(5);
        chk("frame_pairs", 16'(opair), 16'd64);

        // Reset mid-frame at k=20 with a pair presented.
        for (int i = 0; i < 20; i++) send_rand();
        RST = 1'b1;
        send_rand();
        RST = 1'b0;
        chk("flush_valid0", 16'(out_valid), 16'h0);
        set_lit(16'h3000, 16'h0000, L1Test2, 16'h0000, 1'b1);
        send(16'h4000, 16'h0000, 16'h2000, 16'h0000);
        chk("flush_valid1", 16'(out_valid), 16'h0);
        idle(1);
        chk("flush_valid2", 16'(out_valid), 16'h0);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
